// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, phase encodings and helpers
// for the multi-cycle control sequencer.
package ctrl_pkg;

  typedef enum logic [5:0] {
    ST_HALT    = 6'b000000,
    ST_FETCH   = 6'b000001,
    ST_DECODE  = 6'b000010,
    ST_REGREAD = 6'b000100,
    ST_EXEC    = 6'b001000,
    ST_MEM     = 6'b010000,
    ST_WB      = 6'b100000
  } state_e;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  function automatic logic is_mem_op(
    input logic [3:0] opc
  );
    return (opc == OP_READ) || (opc == OP_WRITE);
  endfunction

endpackage

// File: rtl/mem_hs_ctrl.sv
// mem_hs_ctrl: memory request / wait / timeout handshake
// shared by the FETCH and MEM phases.
module mem_hs_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic active_i,
  input  logic mem_ready_i,
  input  logic data_ready_i,
  input  logic posted_i,
  output logic req_o,
  output logic done_o,
  output logic tmo_o
);

  localparam logic [TO_W-1:0] TO_V = TO_W'(TIMEOUT);

  logic            wait_q, wait_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] cnt_inc;

  // A posted write finishes on the first wait cycle;
  // reads need data_ready. Data beats the timeout.
  assign req_o   = active_i & ~wait_q & mem_ready_i;
  assign done_o  = wait_q & (posted_i | data_ready_i);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);
  assign tmo_o   = wait_q & ~done_o & (cnt_inc == TO_V);

  // Next wait flag and saturating wait counter.
  always_comb begin
    wait_d = wait_q;
    cnt_d  = cnt_q;
    if (req_o) begin
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (wait_q) begin
      cnt_d = cnt_inc;
      if (done_o || tmo_o) begin
        wait_d = 1'b0;
      end
    end
  end

  // Handshake state registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wait_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: one-hot six-phase instruction sequencer.
// Optional perf counters: define CTRL_PERF_CNT_EN.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_LSB = 12,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [INSTR_W-1:0] I_instruction,
  input  logic               I_mem_ready,
  input  logic               I_data_ready,
  input  logic               I_stall,
  output logic [5:0]         O_state,
  output logic               O_mem_req,
  output logic               O_mem_we,
  output logic               O_retire,
`ifdef CTRL_PERF_CNT_EN
  output logic               O_fault,
  output logic [31:0]        O_cycles,
  output logic [31:0]        O_instret
`else
  output logic               O_fault
`endif
);

  state_e     state_q, state_d;
  logic       fault_q, fault_d;
  logic [3:0] opc;
  logic       in_fetch, in_mem;
  logic       hs_req, hs_done, hs_tmo;
  logic       is_wr;
  logic       unused_instr;

  assign opc          = I_instruction[OPC_LSB +: 4];
  assign unused_instr = ^I_instruction;
  assign in_fetch     = (state_q == ST_FETCH);
  assign in_mem       = (state_q == ST_MEM);
  assign is_wr        = (opc == OP_WRITE);

  mem_hs_ctrl #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_hs (
    .I_clk        (I_clk),
    .I_reset      (I_reset),
    .active_i     (in_fetch | in_mem),
    .mem_ready_i  (I_mem_ready),
    .data_ready_i (I_data_ready),
    .posted_i     (in_mem & is_wr),
    .req_o        (hs_req),
    .done_o       (hs_done),
    .tmo_o        (hs_tmo)
  );

  // Phase sequencing; a timeout halts until reset.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q | hs_tmo;
    unique case (state_q)
      ST_FETCH: begin
        if (hs_tmo) state_d = ST_HALT;
        else if (hs_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!I_stall) state_d = ST_REGREAD;
      end
      ST_REGREAD: begin
        if (!I_stall) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!I_stall) begin
          state_d = is_mem_op(opc) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (hs_tmo) state_d = ST_HALT;
        else if (hs_done) state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // Phase and sticky fault registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign O_state   = state_q;
  assign O_mem_req = hs_req;
  assign O_mem_we  = hs_req & in_mem & is_wr;
  assign O_retire  = (state_q == ST_WB);
  assign O_fault   = fault_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    cyc_d = fault_q ? cyc_q : cyc_q + 32'd1;
    ret_d = O_retire ? ret_q + 32'd1 : ret_q;
  end

  // Performance counter registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign O_cycles  = cyc_q;
  assign O_instret = ret_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed vectors for ctrl_seq,
// built with TIMEOUT=4.
module tb_ctrl_seq;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic [15:0] I_instruction;
  logic        I_mem_ready;
  logic        I_data_ready;
  logic        I_stall;
  logic [5:0]  O_state;
  logic        O_mem_req;
  logic        O_mem_we;
  logic        O_retire;
  logic        O_fault;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] O_cycles;
  logic [31:0] O_instret;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  logic efault = 1'b0;

  always #5 I_clk = ~I_clk;

  ctrl_seq #(
    .INSTR_W (16),
    .OPC_LSB (12),
    .TIMEOUT (4),
    .TO_W    (8)
  ) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_instruction (I_instruction),
    .I_mem_ready   (I_mem_ready),
    .I_data_ready  (I_data_ready),
    .I_stall       (I_stall),
    .O_state       (O_state),
    .O_mem_req     (O_mem_req),
    .O_mem_we      (O_mem_we),
    .O_retire      (O_retire),
`ifdef CTRL_PERF_CNT_EN
    .O_fault       (O_fault),
    .O_cycles      (O_cycles),
    .O_instret     (O_instret)
`else
    .O_fault       (O_fault)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(
    input string      tag,
    input logic       mr,
    input logic       dr,
    input logic [5:0] es,
    input logic       ereq,
    input logic       ewe,
    input logic       eret
  );
    I_mem_ready  = mr;
    I_data_ready = dr;
    @(negedge I_clk);
    check({tag, ".state"}, 32'(O_state), 32'(es));
    check({tag, ".req"}, 32'(O_mem_req), 32'(ereq));
    check({tag, ".we"}, 32'(O_mem_we), 32'(ewe));
    check({tag, ".ret"}, 32'(O_retire), 32'(eret));
    check({tag, ".flt"}, 32'(O_fault), 32'(efault));
    @(posedge I_clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    step(tag, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic front(input string tag);
    fetch(tag);
    step(tag, 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    I_reset       = 1'b1;
    I_instruction = 16'h0000;
    I_mem_ready   = 1'b0;
    I_data_ready  = 1'b0;
    I_stall       = 1'b0;
    @(posedge I_clk);
    #1;
    @(negedge I_clk);
    check("rst.state", 32'(O_state), 32'h01);
    check("rst.req", 32'(O_mem_req), 32'h0);
    check("rst.we", 32'(O_mem_we), 32'h0);
    check("rst.ret", 32'(O_retire), 32'h0);
    check("rst.flt", 32'(O_fault), 32'h0);
    @(posedge I_clk);
    #1;
    I_reset = 1'b0;

    // ADD: mem_ready held high, no second request
    I_instruction = 16'h0000;
    step("add", 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
    step("add", 1'b1, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("add", 1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step("add", 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
    step("add", 1'b0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step("add", 1'b0, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
    step("add", 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b1);
    step("add", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    // OP_READ: waits in MEM for data_ready
    I_instruction = 16'h1234;
    front("rd");
    step("rd", 1'b1, 1'b0, 6'h10, 1'b1, 1'b0, 1'b0);
    step("rd", 1'b1, 1'b0, 6'h10, 1'b0, 1'b0, 1'b0);
    step("rd", 1'b0, 1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
    step("rd", 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b1);
    step("rd", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    // OP_WRITE: posted, no data_ready needed
    I_instruction = 16'h2000;
    front("wr");
    step("wr", 1'b1, 1'b0, 6'h10, 1'b1, 1'b1, 1'b0);
    step("wr", 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 1'b0);
    step("wr", 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b1);
    step("wr", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    // Stall in REGREAD for 3 cycles
    I_instruction = 16'h0abc;
    fetch("stl");
    step("stl", 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
    I_stall = 1'b1;
    step("stl", 1'b1, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step("stl", 1'b1, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step("stl", 1'b1, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    I_stall = 1'b0;
    step("stl", 1'b0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step("stl", 1'b0, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
    I_stall = 1'b1;
    step("stl", 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b1);
    step("stl", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    I_stall = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    check("perf.ret4", O_instret, 32'd4);
`endif

    // Data on the last allowed wait cycle wins
    I_instruction = 16'h0000;
    step("edge", 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h04, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0);
    step("edge", 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b1);
    step("edge", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    // Timeout after 4 wait cycles; halted until reset
    step("tmo", 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0);
    step("tmo", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("tmo", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("tmo", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("tmo", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    efault = 1'b1;
    step("halt", 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    step("halt", 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    step("halt", 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
    I_reset = 1'b1;
    @(posedge I_clk);
    #1;
    I_reset = 1'b0;
    efault  = 1'b0;
    step("unhalt", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    // Reset during a MEM read wait
    I_instruction = 16'h1234;
    front("rmw");
    step("rmw", 1'b1, 1'b0, 6'h10, 1'b1, 1'b0, 1'b0);
    step("rmw", 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 1'b0);
    I_reset = 1'b1;
    @(posedge I_clk);
    #1;
    I_reset = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    check("perf.cyc0", O_cycles, 32'd0);
    check("perf.ret0", O_instret, 32'd0);
`endif
    step("rmw", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);
    step("rmw", 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    check("perf.cyc2", O_cycles, 32'd2);
`endif
    step("rmw", 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step("rmw", 1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised multi-cycle control sequencer for the CPU core. It drives a one-hot six-phase instruction cycle: fetch, decode, register read, execute, memory, writeback. Memory handshakes run on a ready/req/data-ready protocol, with a bounded wait timeout and a pipeline stall input. It sits between the instruction register, the memory interface and the datapath enables, and is the generalised successor of the fixed 16-bit sequencer.

Parameters:
INSTR_W, 16, instruction width in bits.
OPC_LSB, 12, LSB of the 4-bit opcode field; OPC_LSB+3 must be < INSTR_W.
TIMEOUT, 15, max cycles spent waiting on I_data_ready before fault; range 1..255.
TO_W, 8, width of the timeout counter.

Ports:
I_clk  in  1  clock
I_reset  in  1  synchronous reset, active-high
I_instruction  in  INSTR_W  current instruction register contents
I_mem_ready  in  1  memory able to accept a request
I_data_ready  in  1  memory transaction complete
I_stall  in  1  hold the sequencer in decode/regread/execute
O_state  out  6  one-hot phase: [0] FETCH, [1] DECODE, [2] REGREAD, [3] EXEC, [4] MEM, [5] WB
O_mem_req  out  1  single-cycle memory request pulse
O_mem_we  out  1  write qualifier, valid while O_mem_req=1
O_retire  out  1  single-cycle pulse on WB exit
O_fault  out  1  sticky timeout fault

Behaviour:
- Reset, synchronous, overrides everything including a wait in progress:
  - O_state=6'b000001; O_mem_req=0; O_mem_we=0; O_retire=0; O_fault=0.
  - Internal wait flag=0; timeout counter=0.
- The opcode is I_instruction[OPC_LSB+3:OPC_LSB]. Memory ops are OP_READ and OP_WRITE from the package.
- Issue rule, in FETCH or MEM:
  - While not waiting and I_mem_ready=1: O_mem_req=1 for exactly one cycle, wait flag set, counter cleared.
  - No request is issued while the wait flag is set.
- FETCH:
  - O_mem_we=0.
  - While waiting, I_data_ready=1 clears the wait flag and moves to DECODE on the next edge.
- DECODE -> REGREAD -> EXEC: one cycle each when I_stall=0. With I_stall=1 the state holds.
- EXEC:
  - Opcode OP_READ or OP_WRITE: go to MEM.
  - Otherwise: go to WB.
  - No request is issued in EXEC.
- MEM:
  - Request issued per the issue rule; O_mem_we=1 for OP_WRITE.
  - OP_WRITE completes on the cycle after the request: posted, I_data_ready ignored.
  - OP_READ waits for I_data_ready=1, then goes to WB.
- WB: one cycle, then FETCH. O_retire=1 during the cycle WB is exited.
- Timeout:
  - While waiting, the counter increments each cycle.
  - If it reaches TIMEOUT without I_data_ready: O_fault=1, wait flag cleared, O_state=6'b000000 (IDLE/halted).
  - Only reset leaves the halted state.
- Simultaneous I_data_ready and counter==TIMEOUT: data wins, no fault.
- I_data_ready while not waiting is ignored.
- I_stall is ignored in FETCH, MEM and WB.
- The counter saturates; it never wraps.
- O_state is always one-hot, or all-zero only in fault.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined:
  - Adds outputs O_cycles[31:0] and O_instret[31:0], both cleared by reset.
  - O_cycles increments every non-fault cycle.
  - O_instret increments on each O_retire pulse.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg:
  - Opcode constants OP_READ=4'h1 and OP_WRITE=4'h2 (alongside the existing ALU op codes).
  - State one-hot localparams ST_FETCH..ST_WB and ST_HALT=0.
- Sub-module mem_hs_ctrl: request/wait/timeout handshake, instantiated once and shared by FETCH and MEM.

Test Plan:
- ADD (opcode 4'h0), mem_ready=1, data_ready 2 cycles after req -> O_state sequence 01,02,04,08,20,01; one O_mem_req in FETCH; O_retire pulses once; 7 cycles total.
- OP_READ 16'h1234 -> MEM entered, O_mem_req pulse with O_mem_we=0, WB only after data_ready; two requests per instruction.
- OP_WRITE 16'h2000 -> O_mem_we=1 with req; MEM->WB next cycle regardless of data_ready.
- I_stall=1 for 3 cycles in REGREAD -> state holds 04 for 3 extra cycles, then proceeds; no extra O_mem_req.
- TIMEOUT=4, data_ready never asserted in FETCH -> O_fault=1, O_state=0 after 4 wait cycles; stays halted until I_reset.
- Reset asserted mid-MEM wait -> next cycle O_state=01, O_mem_req=0; data_ready then arrives and is ignored. With CTRL_PERF_CNT_EN, counters read 0.
